// File: rtl/serial_adder.sv
// serial_adder: digit-serial adder/subtractor.
// Adds one DIGIT-bit slice per cycle, least significant slice first, with the
// carry held in a register between slices. A result takes WIDTH/DIGIT RUN
// cycles followed by a single DONE cycle. WIDTH must be a multiple of DIGIT.
// Optional feature macro: SERIAL_ADDER_SUB_EN enables subtract mode through
// the sub port. Without it, sub is accepted but has no effect.
module serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  logic [CW-1:0]    cnt_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             carry_r;
  logic [WIDTH-1:0] sum_r;
  logic [WIDTH-1:0] s_r;
  logic             cout_r;
  logic             busy_r;
  logic             done_r;

  logic             cnt_last_s;
  logic             cin_eff_s;
  logic [DIGIT-1:0] b_slice_s;
  logic [DIGIT:0]   slice_s;
  logic [WIDTH-1:0] sum_next_s;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub_r;

  // Subtract mode: the latched sub selects the inverted operand; carry-in is forced to 1.
  assign cin_eff_s = sub ? 1'b1 : Cin;
  assign b_slice_s = sub_r ? ~b_r[DIGIT-1:0] : b_r[DIGIT-1:0];
`else
  logic unused_sub_s;

  assign unused_sub_s = sub;
  assign cin_eff_s    = Cin;
  assign b_slice_s    = b_r[DIGIT-1:0];
`endif

  assign cnt_last_s = (cnt_r == CW'(N - 1));

  // One slice add. The carry register holds the latched carry-in for slice 0.
  assign slice_s = {1'b0, a_r[DIGIT-1:0]} + {1'b0, b_slice_s} + {{DIGIT{1'b0}}, carry_r};

  // The slice result enters at the top of the partial sum. After N slices, the partial sum is fully aligned.
  assign sum_next_s = (sum_r >> DIGIT) | (WIDTH'(slice_s[DIGIT-1:0]) << (WIDTH - DIGIT));

  // Next-state logic for the IDLE -> RUN -> DONE sequence.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = RUN;
        end else begin
          state_next_s = IDLE;
        end
      end
      RUN: begin
        if (cnt_last_s) begin
          state_next_s = DONE;
        end else begin
          state_next_s = RUN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register. busy and done are registered from the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == RUN);
      done_r  <= (state_next_s == DONE);
    end
  end

  // Operand latch, slice shifting, and result capture on the final slice.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r   <= {CW{1'b0}};
      a_r     <= {WIDTH{1'b0}};
      b_r     <= {WIDTH{1'b0}};
      carry_r <= 1'b0;
      sum_r   <= {WIDTH{1'b0}};
      s_r     <= {WIDTH{1'b0}};
      cout_r  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      sub_r   <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            a_r     <= A;
            b_r     <= B;
            carry_r <= cin_eff_s;
            cnt_r   <= {CW{1'b0}};
            sum_r   <= {WIDTH{1'b0}};
`ifdef SERIAL_ADDER_SUB_EN
            sub_r   <= sub;
`endif
          end
        end
        RUN: begin
          a_r     <= a_r >> DIGIT;
          b_r     <= b_r >> DIGIT;
          carry_r <= slice_s[DIGIT];
          sum_r   <= sum_next_s;
          cnt_r   <= cnt_r + CW'(1);
          if (cnt_last_s) begin
            s_r    <= sum_next_s;
            cout_r <= slice_s[DIGIT];
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign S    = s_r;
  assign Cout = cout_r;

endmodule

// File: tb/tb_serial_adder.sv
// Directed testbench for serial_adder (WIDTH=16, DIGIT=4) plus a DIGIT=16 instance.
module tb_serial_adder;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        busy;
  logic        done;
  logic [15:0] s;
  logic        cout;

  logic        start2;
  logic [15:0] a2;
  logic [15:0] b2;
  logic        busy2;
  logic        done2;
  logic [15:0] s2;
  logic        cout2;

  int checks;
  int errors;

  serial_adder #(.WIDTH(16), .DIGIT(4)) dut (
    .clk(clk), .reset(reset), .start(start), .A(a), .B(b), .Cin(cin), .sub(sub),
    .busy(busy), .done(done), .S(s), .Cout(cout)
  );

  serial_adder #(.WIDTH(16), .DIGIT(16)) dut16 (
    .clk(clk), .reset(reset), .start(start2), .A(a2), .B(b2), .Cin(1'b0), .sub(1'b0),
    .busy(busy2), .done(done2), .S(s2), .Cout(cout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch a one-cycle start pulse, then check busy/done timing and the result.
  task automatic do_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic cv, input logic sv,
                       input logic [15:0] exp_s, input logic exp_c);
    a = av; b = bv; cin = cv; sub = sv; start = 1'b1;
    tick();
    start = 1'b0;
    a = 16'h0000; b = 16'h0000; cin = 1'b0; sub = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      check({tag, "_nodone"}, {31'd0, done}, 32'd0);
      tick();
    end
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    check({tag, "_s"}, {16'd0, s}, {16'd0, exp_s});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_c});
    tick();
    check({tag, "_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_hold"}, {16'd0, s}, {16'd0, exp_s});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1; start = 1'b0; a = 16'h0000; b = 16'h0000; cin = 1'b0; sub = 1'b0;
    start2 = 1'b0; a2 = 16'h0000; b2 = 16'h0000;
    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_s", {16'd0, s}, 32'd0);
    check("rst_cout", {31'd0, cout}, 32'd0);
    check("rst16_s", {16'd0, s2}, 32'd0);
    reset = 1'b0;
    tick();

    do_op("alt", 16'h5555, 16'hAAAA, 1'b0, 1'b0, 16'hFFFF, 1'b0);
    do_op("ripple", 16'h0000, 16'hFFFF, 1'b1, 1'b0, 16'h0000, 1'b1);
    do_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    do_op("mixed", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0);
`ifdef SERIAL_ADDER_SUB_EN
    do_op("sub", 16'h0006, 16'h0001, 1'b0, 1'b1, 16'h0005, 1'b1);
`else
    do_op("sub", 16'h0006, 16'h0001, 1'b0, 1'b1, 16'h0007, 1'b0);
`endif

    // start held high; operands change after the latch edge k.
    a = 16'h1111; b = 16'h2222; cin = 1'b0; start = 1'b1;
    tick();
    a = 16'hFFFF; b = 16'hFFFF;
    tick(); tick(); tick(); tick();
    check("held_done", {31'd0, done}, 32'd1);
    check("held_s", {16'd0, s}, 32'h3333);
    check("held_cout", {31'd0, cout}, 32'd0);
    tick();
    check("held_idle", {31'd0, busy}, 32'd0);
    tick();
    check("held_restart", {31'd0, busy}, 32'd1);
    check("held_keep_s", {16'd0, s}, 32'h3333);
    start = 1'b0;
    tick(); tick(); tick(); tick();
    check("held2_done", {31'd0, done}, 32'd1);
    check("held2_s", {16'd0, s}, 32'hFFFE);
    check("held2_cout", {31'd0, cout}, 32'd1);
    tick();

    // Reset sampled at edge k+2 aborts the operation.
    a = 16'h0F0F; b = 16'h0101; cin = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_s", {16'd0, s}, 32'd0);
    check("abort_cout", {31'd0, cout}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("abort_nodone", {31'd0, done}, 32'd0);
    end

    // Single-slice instance: done one cycle after the latch edge.
    a2 = 16'h0101; b2 = 16'h1010; start2 = 1'b1;
    tick();
    start2 = 1'b0;
    a2 = 16'h0000; b2 = 16'h0000;
    check("d16_busy", {31'd0, busy2}, 32'd1);
    check("d16_nodone", {31'd0, done2}, 32'd0);
    tick();
    check("d16_done", {31'd0, done2}, 32'd1);
    check("d16_s", {16'd0, s2}, 32'h1111);
    check("d16_cout", {31'd0, cout2}, 32'd0);
    tick();
    check("d16_pulse", {31'd0, done2}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, meaning operand/sum width in bits.
REQ-002 The module SHALL have parameter DIGIT, default 4, meaning bits added per cycle; WIDTH mod DIGIT SHALL be 0; N = WIDTH/DIGIT.
REQ-003 The module SHALL have port clk, input, 1, meaning the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1, meaning synchronous, active-high reset.
REQ-005 The module SHALL have port start, input, 1, meaning request to begin an addition.
REQ-006 The module SHALL have ports A and B, input, WIDTH, meaning operands.
REQ-007 The module SHALL have port Cin, input, 1, meaning carry-in.
REQ-008 The module SHALL have port sub, input, 1, meaning subtract mode (see Configuration).
REQ-009 The module SHALL have port busy, output, 1, meaning an operation is in progress.
REQ-010 The module SHALL have port done, output, 1, meaning a one-cycle result-valid pulse.
REQ-011 The module SHALL have port S, output, WIDTH, meaning the sum.
REQ-012 The module SHALL have port Cout, output, 1, meaning carry-out of the MSB.

Function
REQ-013 The module SHALL implement states IDLE, RUN and DONE, with transitions IDLE->RUN on start=1, RUN->DONE after N RUN cycles, and DONE->IDLE unconditionally.
REQ-014 The module SHALL, on the edge where start=1 is sampled in IDLE, latch A, B, Cin and sub into internal registers and clear the digit counter.
REQ-015 Each RUN cycle SHALL add one DIGIT-bit slice, LSB slice first, using a registered carry chained from the previous slice; slice 0 SHALL use the latched Cin.
REQ-016 busy SHALL be 1 exactly in RUN; done SHALL be 1 exactly in DONE.
REQ-017 If start is sampled at edge k, then done SHALL be high in the cycle following edge k+N, and busy SHALL be high in the cycles following edges k..k+N-1.
REQ-018 S and Cout SHALL change only on the edge entering DONE, and SHALL hold until the next completion or reset.
REQ-019 S SHALL equal (A + B' + c) mod 2^WIDTH and Cout SHALL equal bit WIDTH of that full sum, where B' and c are defined in Configuration.
REQ-020 start SHALL be ignored in RUN and DONE, and input changes after the latch edge SHALL NOT affect the result.
REQ-021 A start asserted continuously SHALL begin a new operation on the first IDLE cycle, giving a throughput of one result per N+2 cycles.
REQ-022 When DIGIT = WIDTH, the module SHALL use N = 1, with done appearing one cycle after the latch edge.

Reset
REQ-023 When reset=1 is sampled, the module SHALL enter IDLE and set busy=0, done=0, S=0, Cout=0, and clear the internal operand, carry and counter registers.
REQ-024 Reset SHALL take priority over start, and a reset in RUN or DONE SHALL abort the operation with no done pulse.

Configuration
REQ-025 With macro SERIAL_ADDER_SUB_EN defined, sub=1 latched SHALL give B' = ~B and c = 1 (Cin ignored), so that S = A - B and Cout = 1 means no borrow; sub=0 SHALL give B' = B and c = Cin.
REQ-026 With SERIAL_ADDER_SUB_EN undefined, the sub port SHALL remain present but be ignored, with B' = B and c = Cin always.

Verification (WIDTH=16, DIGIT=4, N=4)
REQ-027 Stimulus A=0x5555, B=0xAAAA, Cin=0, start pulse at edge k -> busy high for 4 cycles, done high for exactly 1 cycle after edge k+4, S=0xFFFF, Cout=0.
REQ-028 Stimulus A=0x0000, B=0xFFFF, Cin=1 -> S=0x0000, Cout=1 (carry ripples across all 4 slices).
REQ-029 Stimulus A=0x0006, B=0x0001, sub=1 -> with SERIAL_ADDER_SUB_EN: S=0x0005, Cout=1; without it: S=0x0007, Cout=0.
REQ-030 Stimulus: start held high with operands changed mid-RUN -> the result uses the latched operands, and the next operation begins at edge k+6.
REQ-031 Stimulus: reset asserted at edge k+2 of an operation -> no done pulse, and busy, done, S and Cout are all 0 on the following cycle.
REQ-032 Stimulus with DIGIT=16: A=0x0101, B=0x1010 -> done one cycle after start, S=0x1111, Cout=0.
